// File: rtl/bsg_dff_en_rr_writer.sv
// bsg_dff_en_rr_writer
// Round-robin write controller for a shared holding register. Several
// requesters compete to load one width_p-bit register. At most one winner is
// granted per cycle through a v/yumi handshake, and the register captures the
// winner's data on the next edge. A winner that also raises lock_i becomes the
// exclusive owner. It keeps that ownership until it drops its lock bit.
module bsg_dff_en_rr_writer #(
    parameter int width_p   = 64,
    parameter int els_p     = 4,
    parameter int lg_els_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         v_i,
    input  logic [els_p-1:0]         lock_i,
    input  logic [els_p*width_p-1:0] data_i,
    output logic [els_p-1:0]         yumi_o,
    output logic [width_p-1:0]       data_o,
    output logic                     v_o,
    output logic [lg_els_lp-1:0]     owner_o,
    output logic                     locked_o,
    output logic [15:0]              wr_count_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;

    // last_r: the most recent winner. The search starts one index above it.
    logic [lg_els_lp-1:0]   r_last;
    logic [lg_els_lp-1:0]   r_owner;
    logic [width_p-1:0]     r_data;
    logic                   r_v;
    logic [15:0]            r_wr_count;

    // Result of the round-robin scan in IDLE.
    logic                   w_rr_found;
    logic [lg_els_lp-1:0]   w_rr_idx;

    // Final grant decision after state and reset qualification.
    logic                   w_gnt_vld;
    logic [lg_els_lp-1:0]   w_gnt_idx;
    logic [width_p-1:0]     w_wdata;

    // Scan upward from last_r+1 with wrap-around. The first valid index wins.
    always_comb begin
        int                   w_sum;
        logic [lg_els_lp-1:0] w_cand;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_sum      = 0;
        w_cand     = '0;
        for (int i = 1; i <= els_p; i++) begin
            w_sum  = (int'(r_last) + i) % els_p;
            w_cand = lg_els_lp'(w_sum);
            if (!w_rr_found && v_i[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    // FSM output logic: grant selection and the one-hot yumi.
    // In LOCKED only the owner can win, and only if it is valid. Reset masks
    // every grant, so no write can coincide with reset.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (!reset_i) begin
            if (r_state == ST_IDLE) begin
                w_gnt_vld = w_rr_found;
                w_gnt_idx = w_rr_idx;
            end else begin
                w_gnt_vld = v_i[r_owner];
                w_gnt_idx = r_owner;
            end
        end
        yumi_o = '0;
        if (w_gnt_vld) begin
            yumi_o[w_gnt_idx] = 1'b1;
        end
    end

    // FSM next-state logic.
    // A lock is entered when the IDLE winner also requests a lock. A lock is
    // released by the owner's lock bit, which is sampled whether or not the
    // owner writes in that cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld && lock_i[w_gnt_idx]) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!lock_i[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only the winner's slice is selected, so values on unselected slices,
    // including X, never reach the holding register.
    always_comb begin
        w_wdata = data_i[int'(w_gnt_idx)*width_p +: width_p];
    end

    // Holding register, owner, pointer and write counter. They update only on
    // a grant. The pointer resets to els_p-1 so that requester 0 has first
    // priority after reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_data     <= '0;
            r_v        <= 1'b0;
            r_owner    <= '0;
            r_last     <= lg_els_lp'(els_p - 1);
            r_wr_count <= '0;
        end else if (w_gnt_vld) begin
            r_data  <= w_wdata;
            r_v     <= 1'b1;
            r_owner <= w_gnt_idx;
            r_last  <= w_gnt_idx;
            if (r_wr_count != 16'hFFFF) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign data_o     = r_data;
    assign v_o        = r_v;
    assign owner_o    = r_owner;
    assign locked_o   = (r_state == ST_LOCKED);
    assign wr_count_o = r_wr_count;

endmodule

// File: tb/tb_bsg_dff_en_rr_writer.sv
// Testbench for bsg_dff_en_rr_writer. A reference model predicts each grant
// at the negative edge. Granted data is queued and then compared with data_o
// after the next rising edge.
module tb_bsg_dff_en_rr_writer;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int LG = 2;

    logic             clk;
    logic             reset_i;
    logic [N-1:0]     v_i;
    logic [N-1:0]     lock_i;
    logic [N*W-1:0]   data_i;
    logic [N-1:0]     yumi_o;
    logic [W-1:0]     data_o;
    logic             v_o;
    logic [LG-1:0]    owner_o;
    logic             locked_o;
    logic [15:0]      wr_count_o;

    bsg_dff_en_rr_writer #(.width_p(W), .els_p(N)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .lock_i     (lock_i),
        .data_i     (data_i),
        .yumi_o     (yumi_o),
        .data_o     (data_o),
        .v_o        (v_o),
        .owner_o    (owner_o),
        .locked_o   (locked_o),
        .wr_count_o (wr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           k;
    } wr_t;

    wr_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;

    // Reference model state
    logic         m_locked = 1'b0;
    int           m_last   = N - 1;
    int           m_owner  = 0;
    logic         m_vo     = 1'b0;
    logic [15:0]  m_cnt    = 16'd0;
    logic [W-1:0] m_data   = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] g;
        g = '0;
        if (reset_i) return g;
        if (m_locked) begin
            if (v_i[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int s = 1; s <= N; s++) begin
            int k;
            k = (m_last + s) % N;
            if (v_i[k]) begin
                g[k] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) data_i[i*W +: W] = {$urandom(), $urandom()};
    endtask

    // Run one clock cycle. Called at posedge+1 with the inputs already set.
    task automatic cyc();
        logic [N-1:0] g;
        int           k;
        wr_t          e;
        wr_t          p;
        @(negedge clk);
        g = model_gnt();
        chk("yumi", yumi_o, g);
        if (reset_i) begin
            m_locked = 1'b0;
            m_last   = N - 1;
            m_owner  = 0;
            m_vo     = 1'b0;
            m_cnt    = 16'd0;
            m_data   = '0;
            sb.delete();
        end else begin
            k = -1;
            for (int i = 0; i < N; i++) if (g[i]) k = i;
            if (k >= 0) begin
                e.d = data_i[k*W +: W];
                e.k = k;
                sb.push_back(e);
            end
            if (m_locked) m_locked = lock_i[m_owner];
            else          m_locked = (k >= 0) && lock_i[k];
            if (k >= 0) begin
                m_last  = k;
                m_owner = k;
                m_vo    = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            p = sb.pop_front();
            m_data = p.d;
            chk("data_o", data_o, p.d);
        end else begin
            chk("data_hold", data_o, m_data);
        end
        chk("owner_o", owner_o, m_owner);
        chk("v_o", v_o, m_vo);
        chk("wr_count_o", wr_count_o, m_cnt);
        chk("locked_o", locked_o, m_locked);
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 4'b1111;
        lock_i  = 4'b0000;
        rand_data();
        @(posedge clk);
        #1;
        // Reset for 2 cycles with all requesters valid
        cyc();
        cyc();
        reset_i = 1'b0;
        v_i = 4'b0000;
        cyc();

        // Single requester
        v_i = 4'b0100;
        rand_data();
        data_i[2*W +: W] = 64'hDEAD_BEEF_0000_0002;
        cyc();
        chk("single_data", data_o, 64'hDEAD_BEEF_0000_0002);
        chk("single_owner", owner_o, 2);
        v_i = 4'b0000;
        cyc();

        // Full contention right after reset: grants 0,1,2,3,0,1
        reset_i = 1'b1; cyc(); reset_i = 1'b0;
        v_i = 4'b1111;
        repeat (6) begin rand_data(); cyc(); end
        chk("contention_cnt", wr_count_o, 16'd6);
        chk("contention_owner", owner_o, 1);

        // Lock by requester 1, then hold off others
        reset_i = 1'b1; cyc(); reset_i = 1'b0;
        v_i = 4'b0010; lock_i = 4'b0010; rand_data(); cyc();
        chk("lock_entry", locked_o, 1'b1);
        v_i = 4'b1111;
        repeat (3) begin rand_data(); cyc(); end
        lock_i = 4'b0000; rand_data(); cyc();
        chk("lock_final_owner", owner_o, 1);
        rand_data(); cyc();
        chk("after_unlock_owner", owner_o, 2);

        // Reset while locked
        v_i = 4'b0001; lock_i = 4'b0001; rand_data(); cyc();
        chk("relock", locked_o, 1'b1);
        v_i = 4'b1111; reset_i = 1'b1; rand_data(); cyc();
        chk("midlock_data", data_o, 64'd0);
        reset_i = 1'b0; lock_i = 4'b0000; rand_data(); cyc();
        chk("post_reset_owner", owner_o, 0);

        // Random mix of valids and locks
        repeat (300) begin
            v_i    = 4'($urandom());
            lock_i = 4'($urandom() & $urandom());
            rand_data();
            cyc();
        end

        // Saturation
        reset_i = 1'b1; lock_i = 4'b0000; cyc(); reset_i = 1'b0;
        v_i = 4'b0001;
        repeat (65540) begin rand_data(); cyc(); end
        chk("sat_cnt", wr_count_o, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
